// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: holding-register handshake between the UART receiver and
// its byte consumer.
//   data_out   received word, stable while data_valid is high
//   data_valid word available, held until accepted
//   data_ready consumer accepts data_out on a cycle where data_valid is high
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a valid/ready holding register,
// parity checking, frame/overrun error pulses and a debug state output.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   rx_raw          unsynchronised serial input, idle high
//   bus (master)    data_out / data_valid / data_ready holding-register handshake
//   frame_error     1-cycle pulse, a stop bit sampled low
//   parity_error    1-cycle pulse, parity mismatch at frame end
//   overrun_error   1-cycle pulse, clean word completed while holding register full
//   busy            receiver FSM not idle
//   state           FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4), debug only
// Build option: define UART_RX_MAJORITY_EN to take every sample as the 2-of-3
// majority of the last three synchronised rx values (rejects 1-cycle glitches).
module uart_rx_param #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_raw,
  uart_rx_param_if.master        bus,
  output logic                   frame_error,
  output logic                   parity_error,
  output logic                   overrun_error,
  output logic                   busy,
  output logic [2:0]             state
);

  localparam int unsigned BIT_TICKS  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
  localparam int unsigned CNT_W      = $clog2(BIT_TICKS);
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_d, pe_d, oe_d, busy_d;
  logic                 commit_c;
  logic                 full_tick_c;
  logic                 sample_c;

  // Input synchroniser plus sample history; idle-high reset values.
  logic sync1, sync2, rx_prev;
`ifdef UART_RX_MAJORITY_EN
  logic rx_prev2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_prev  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      rx_prev2 <= 1'b1;
`endif
    end else begin
      sync1    <= rx_raw;
      sync2    <= sync1;
      rx_prev  <= sync2;
`ifdef UART_RX_MAJORITY_EN
      rx_prev2 <= rx_prev;
`endif
    end
  end

  // Bit sample value used by every START/data/parity/stop decision.
`ifdef UART_RX_MAJORITY_EN
  assign sample_c = (sync2 & rx_prev) | (sync2 & rx_prev2) | (rx_prev & rx_prev2);
`else
  assign sample_c = sync2;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      stop_idx_q    <= 1'b0;
      shift_q       <= '0;
      par_bad_q     <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      stop_idx_q    <= stop_idx_d;
      shift_q       <= shift_d;
      par_bad_q     <= par_bad_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_error   <= fe_d;
      parity_error  <= pe_d;
      overrun_error <= oe_d;
      busy          <= busy_d;
    end
  end

  // Next-state, frame checking and holding-register control.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    data_d      = data_q;
    valid_d     = valid_q;
    fe_d        = 1'b0;
    pe_d        = 1'b0;
    oe_d        = 1'b0;
    commit_c    = 1'b0;
    full_tick_c = (cnt_q == CNT_W'(BIT_TICKS - 1));
    // Bit-period counter wraps at BIT_TICKS; IDLE/START override below.
    cnt_d       = full_tick_c ? '0 : cnt_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // Only a 1->0 transition starts a frame, so a held-low break cannot retrigger.
        if (rx_prev && !sync2) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == CNT_W'(HALF_TICKS - 1)) begin
          cnt_d = '0;
          if (!sample_c) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (full_tick_c) begin
          // LSB arrives first; after DATA_BITS shifts it sits at bit 0.
          shift_d = {sample_c, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            par_bad_d  = 1'b0;
            stop_idx_d = 1'b0;
            state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (full_tick_c) begin
          par_bad_d  = (PARITY == 1) ? ~(^shift_q ^ sample_c) : (^shift_q ^ sample_c);
          stop_idx_d = 1'b0;
          state_d    = S_STOP;
        end
      end

      S_STOP: begin
        if (full_tick_c) begin
          if (!sample_c) begin
            fe_d    = 1'b1;
            state_d = S_IDLE;
          end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            if (par_bad_q) begin
              pe_d = 1'b1;
            end else begin
              commit_c = 1'b1;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Holding register: a commit coinciding with an accept reloads without overrun.
    if (commit_c) begin
      if (valid_q && !bus.data_ready) begin
        oe_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && bus.data_ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign state          = 3'(state_q);

endmodule
